// File: rtl/bp_resolve_queue_if.sv
// bp_resolve_queue_if: fetch/execute side bus of the branch resolve queue
interface bp_resolve_queue_if;
  logic        enq_valid;
  logic        enq_ready;
  logic [31:0] enq_pc;
  logic        enq_pred_taken;
  logic [31:0] enq_pred_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_taken;
  logic [31:0] res_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_write;
  logic [31:0] upd_pc;
  logic [31:0] upd_dest_pc;
  logic        upd_taken;
  modport master (
    output enq_valid, enq_pc, enq_pred_taken, enq_pred_pc,
    output res_valid, res_pc, res_taken, res_target,
    input  enq_ready, redirect_valid, redirect_pc,
    input  upd_write, upd_pc, upd_dest_pc, upd_taken
  );
  modport slave (
    input  enq_valid, enq_pc, enq_pred_taken, enq_pred_pc,
    input  res_valid, res_pc, res_taken, res_target,
    output enq_ready, redirect_valid, redirect_pc,
    output upd_write, upd_pc, upd_dest_pc, upd_taken
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// bp_resolve_queue: in-order branch resolve queue with redirect and predictor training
module bp_resolve_queue #(
  parameter int DEPTH    = 8,
  parameter int CNT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  bp_resolve_queue_if.slave       bus,
  input  logic                    flush,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    order_err,
  output logic [CNT_BITS-1:0]     branch_cnt,
  output logic [CNT_BITS-1:0]     mispred_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]      pc_q  [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [DEPTH-1:0] tk_q;
  logic [AW-1:0]    head, tail;
  logic             pop, push, mis, bad;
  always_comb begin
    bus.enq_ready = count != (AW+1)'(DEPTH);
    pop  = bus.res_valid & ~flush & (count != '0);
    bad  = pc_q[head] != bus.res_pc;
    mis  = pop & (bad | (tk_q[head] != bus.res_taken) |
                  (bus.res_taken & (tgt_q[head] != bus.res_target)));
    push = bus.enq_valid & bus.enq_ready & ~flush & ~mis;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]  <= bus.enq_pc;
      tk_q[tail]  <= bus.enq_pred_taken;
      tgt_q[tail] <= bus.enq_pred_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head               <= '0;
      tail               <= '0;
      count              <= '0;
      order_err          <= 1'b0;
      branch_cnt         <= '0;
      mispred_cnt        <= '0;
      bus.redirect_valid <= 1'b0;
      bus.redirect_pc    <= '0;
      bus.upd_write      <= 1'b0;
      bus.upd_pc         <= '0;
      bus.upd_dest_pc    <= '0;
      bus.upd_taken      <= 1'b0;
    end else begin
      bus.redirect_valid <= mis;
      bus.upd_write      <= pop;
      if (mis) bus.redirect_pc <= bus.res_taken ? bus.res_target : bus.res_pc + 32'd4;
      if (pop) begin
        bus.upd_pc      <= bus.res_pc;
        bus.upd_dest_pc <= bus.res_target;
        bus.upd_taken   <= bus.res_taken;
        branch_cnt      <= branch_cnt + 1'b1;
      end
      if (mis) mispred_cnt <= mispred_cnt + 1'b1;
      if (bus.res_valid & ~flush & ((count == '0) | bad)) order_err <= 1'b1;
      // a mispredict squashes every younger entry, so the queue restarts empty
      if (flush | mis) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop) head <= head + 1'b1;
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
endmodule
